// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status readback
module mmio_uart_tx #(
  parameter int          data_width   = 16,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [8:0]  BASE_ADDR    = 9'h100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mem_cmd,
  input  logic [8:0]            mem_addr,
  input  logic [data_width-1:0] din,
  output logic [data_width-1:0] mdata,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int         PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         CW        = $clog2(FIFO_DEPTH + 1);
  localparam int         BW        = $clog2(CLKS_PER_BIT);
  localparam logic [8:0] STAT_ADDR = BASE_ADDR + 9'd1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);
  localparam logic [BW-1:0] BAUD_END = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q;
  logic            wr_hit_q, rd_stat_q;

  logic            wr_hit, rd_stat, rd_data;
  logic            wr_first, rd_stat_first;
  logic            full, empty;
  logic            pop, push_ok, drop;
  logic            baud_end;
  logic            unused_din;

  // Only the low byte of a write carries data.
  assign unused_din = ^din[data_width-1:8];

  // Address decode and first-cycle detection of held commands.
  assign wr_hit        = (mem_cmd == 2'b01) && (mem_addr == BASE_ADDR);
  assign rd_stat       = (mem_cmd == 2'b11) && (mem_addr == STAT_ADDR);
  assign rd_data       = (mem_cmd == 2'b11) && (mem_addr == BASE_ADDR);
  assign wr_first      = wr_hit & ~wr_hit_q;
  assign rd_stat_first = rd_stat & ~rd_stat_q;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push_ok  = wr_first & (~full | pop);
  assign drop     = wr_first & full & ~pop;
  assign baud_end = (baud_q == BAUD_END);

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

  // Read data is purely combinational from the current command; bus released otherwise.
  assign mdata = rd_stat ? {{(data_width-4){1'b0}}, ovf_q, full, empty, tx_busy} :
                 rd_data ? {{(data_width-CW){1'b0}}, count_q} :
                           {data_width{1'bz}};

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because pointers and count gate every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= din[7:0];
    end
  end

  // FIFO pointers, count, sticky overflow flag and command history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      wr_hit_q  <= 1'b0;
      rd_stat_q <= 1'b0;
    end else begin
      wr_hit_q  <= wr_hit;
      rd_stat_q <= rd_stat;
      count_q   <= count_d;
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (rd_stat_first) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Transmitter state register; line returns high at once on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Transmitter next state: tx_d is the line level for the coming cycle, so tx is glitch-free.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx with a frame-level reference model
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [1:0]  mem_cmd  = 2'b00;
  logic [8:0]  mem_addr = 9'h000;
  logic [15:0] din      = 16'h0000;
  wire  [15:0] mdata;
  wire         tx;
  wire         tx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_uart_tx #(
    .data_width  (16),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (9'h100)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mem_cmd (mem_cmd),
    .mem_addr(mem_addr),
    .din     (din),
    .mdata   (mdata),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus "position within current frame".
  logic [7:0] m_q[$];
  bit         m_active  = 1'b0;
  int         m_fcyc    = 0;
  logic [7:0] m_fbyte   = 8'h00;
  bit         m_ovf     = 1'b0;
  bit         m_wr_prev = 1'b0;
  bit         m_rs_prev = 1'b0;
  bit         mm_wr, mm_rs, mm_pop;
  int         mm_sz;
  logic [7:0] mm_b;

  // Receiver that decodes bytes off the line by mid-bit sampling.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         rx_on  = 1'b0;
  int         rx_cyc = 0;
  logic [7:0] rx_sh  = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_fcyc / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_fbyte[k-1];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_active  = 1'b0;
      m_fcyc    = 0;
      m_ovf     = 1'b0;
      m_wr_prev = 1'b0;
      m_rs_prev = 1'b0;
    end else begin
      mm_wr  = (mem_cmd == 2'b01) && (mem_addr == 9'h100);
      mm_rs  = (mem_cmd == 2'b11) && (mem_addr == 9'h101);
      mm_sz  = m_q.size();
      mm_pop = (mm_sz != 0) && (!m_active || m_fcyc == FRAME - 1);
      mm_b   = 8'h00;
      if (mm_pop) mm_b = m_q.pop_front();
      if (mm_wr && !m_wr_prev) begin
        if (mm_sz == DEPTH && !mm_pop) m_ovf = 1'b1;
        else m_q.push_back(din[7:0]);
      end
      if (mm_rs && !m_rs_prev) m_ovf = 1'b0;
      if (m_active) begin
        if (m_fcyc == FRAME - 1) begin
          if (mm_pop) begin
            m_fcyc  = 0;
            m_fbyte = mm_b;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_fcyc++;
        end
      end else if (mm_pop) begin
        m_active = 1'b1;
        m_fcyc   = 0;
        m_fbyte  = mm_b;
      end
      m_wr_prev = mm_wr;
      m_rs_prev = mm_rs;
    end
  end

  // Per-cycle comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    chk("tx", int'(tx), int'(exp_tx()));
    chk("tx_busy", int'(tx_busy), int'(m_active));
    if (mem_cmd == 2'b11 && mem_addr == 9'h101) begin
      chk("mdata_status", int'(mdata),
          (int'(m_ovf) << 3) | (int'(m_q.size() == DEPTH) << 2) |
          (int'(m_q.size() == 0) << 1) | int'(m_active));
    end else if (mem_cmd == 2'b11 && mem_addr == 9'h100) begin
      chk("mdata_count", int'(mdata), m_q.size());
    end else begin
      n_cmp++;
      if (!(mdata === 16'hzzzz)) begin
        n_bad++;
        $display("FAIL mdata_release at %0t: got %h expected zzzz", $time, mdata);
      end
    end
  end

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx == 1'b0) begin
        rx_on  = 1'b1;
        rx_cyc = 0;
      end
    end else begin
      rx_cyc++;
      if ((rx_cyc % CPB) == 2 && (rx_cyc / CPB) >= 1 && (rx_cyc / CPB) <= 8)
        rx_sh[(rx_cyc / CPB) - 1] = tx;
      if (rx_cyc == FRAME - 1) begin
        rx_on = 1'b0;
        rx_q.push_back(rx_sh);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d, input int n);
    mem_cmd  = 2'b01;
    mem_addr = a;
    din      = {8'hEE, d};
    repeat (n) step();
    mem_cmd = 2'b00;
    step();
  endtask

  task automatic rd(input logic [8:0] a, output logic [15:0] v);
    mem_cmd  = 2'b11;
    mem_addr = a;
    #2;
    v = mdata;
    step();
    mem_cmd = 2'b00;
    step();
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      if (!m_active && m_q.size() == 0 && !tx_busy) done = 1'b1;
      else step();
    end
    chk("idle_within_budget", int'(done), 1);
  endtask

  task automatic chk_rx(input string name);
    chk({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({name, "_byte"}, int'(rx_q[i]), int'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    logic [9:0]  seq;
    bit          hit;

    #2 reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    step();

    // Reset state and idle STATUS.
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(tx_busy), 0);
    rd(9'h101, v);
    chk("reset_status", int'(v), 16'h0002);

    // Single byte 0xA5: line sequence pinned literally.
    rx_q.delete();
    seq = 10'b1101001010;
    wr(9'h100, 8'hA5, 1);
    for (int k = 0; k < 10; k++) begin
      chk("a5_bit", int'(tx), int'(seq[k]));
      chk("a5_busy", int'(tx_busy), 1);
      repeat (CPB) step();
    end
    chk("a5_busy_end", int'(tx_busy), 0);
    rd(9'h101, v);
    chk("a5_status_after", int'(v), 16'h0002);
    exp_q = {8'hA5};
    chk_rx("a5_rx");

    // Held write pushes one byte only.
    rx_q.delete();
    mem_cmd  = 2'b01;
    mem_addr = 9'h100;
    din      = 16'h003C;
    repeat (3) step();
    mem_cmd = 2'b00;
    rd(9'h100, v);
    chk("held_count", int'(v), 0);
    wait_idle(200);
    exp_q = {8'h3C};
    chk_rx("held_rx");

    // Overflow while the first frame is on the line.
    rx_q.delete();
    wr(9'h100, 8'h99, 1);
    for (int i = 1; i <= 5; i++) wr(9'h100, 8'(i), 1);
    rd(9'h101, v);
    chk("ovf_status", int'(v), 16'h000D);
    rd(9'h101, v);
    chk("ovf_status_cleared", int'(v), 16'h0005);
    wait_idle(600);
    exp_q = {8'h99, 8'h01, 8'h02, 8'h03, 8'h04};
    chk_rx("ovf_rx");
    rd(9'h101, v);
    chk("ovf_status_idle", int'(v), 16'h0002);

    // Address decode: neighbours of the register window are ignored.
    rx_q.delete();
    wr(9'h101, 8'h55, 1);
    wr(9'h0FF, 8'h66, 1);
    rd(9'h102, v);
    repeat (10) step();
    chk("decode_tx", int'(tx), 1);
    chk("decode_busy", int'(tx_busy), 0);
    rd(9'h101, v);
    chk("decode_status", int'(v), 16'h0002);
    chk("decode_rx_count", rx_q.size(), 0);

    // Reset during data bit 3 with two bytes queued.
    rx_q.delete();
    wr(9'h100, 8'h11, 1);
    wr(9'h100, 8'h22, 1);
    wr(9'h100, 8'h33, 1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_active && m_fcyc == 4 * CPB + 1) hit = 1'b1;
      else step();
    end
    chk("rst_reach_bit3", int'(hit), 1);
    chk("rst_queued", m_q.size(), 2);
    reset = 1'b0;
    #1;
    chk("rst_tx_async", int'(tx), 1);
    chk("rst_busy_async", int'(tx_busy), 0);
    repeat (3) step();
    reset = 1'b1;
    step();
    rd(9'h101, v);
    chk("rst_status", int'(v), 16'h0002);
    repeat (60) step();
    chk("rst_rx_count", rx_q.size(), 0);
    chk("rst_tx_idle", int'(tx), 1);

    // Push on the same edge as the STOP-to-START pop while full.
    rx_q.delete();
    wr(9'h100, 8'hA0, 1);
    wr(9'h100, 8'hB1, 1);
    wr(9'h100, 8'hB2, 1);
    wr(9'h100, 8'hB3, 1);
    wr(9'h100, 8'hB4, 1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_active && m_fcyc == FRAME - 1 && m_q.size() == DEPTH) hit = 1'b1;
      else step();
    end
    chk("pp_reach_stop_end", int'(hit), 1);
    mem_cmd  = 2'b01;
    mem_addr = 9'h100;
    din      = 16'h00C5;
    step();
    mem_cmd = 2'b00;
    step();
    rd(9'h100, v);
    chk("pp_count", int'(v), 4);
    rd(9'h101, v);
    chk("pp_status", int'(v), 16'h0005);
    wait_idle(800);
    exp_q = {8'hA0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC5};
    chk_rx("pp_rx");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
